// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU issue/result path: nibble width, op encodings, FSM states.
package alu4_pkg;

  localparam int ALU_NIBBLE_W    = 4;
  localparam int DEFAULT_LATENCY = 8;

  localparam logic [2:0] OP_XOR   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_ARITH = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CARRY,
    DRAIN,
    DONE
  } seq_state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_XOR) || (op == OP_AND) || (op == OP_ARITH);
  endfunction

endpackage

// File: rtl/alu4_inflight_pipe.sv
// LATENCY-deep shift register of {valid, nibble index}; the head lines up with the ALU return.
module alu4_inflight_pipe #(
  parameter int LATENCY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_index,
  output logic       head_valid,
  output logic [2:0] head_index
);

  logic [LATENCY-1:0] valid_sr;
  logic [2:0]         index_sr [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr <= '0;
      for (int i = 0; i < LATENCY; i++) index_sr[i] <= '0;
    end else begin
      valid_sr    <= {valid_sr[LATENCY-2:0], in_valid};
      index_sr[0] <= in_index;
      for (int i = 1; i < LATENCY; i++) index_sr[i] <= index_sr[i-1];
    end
  end

  assign head_valid = valid_sr[LATENCY-1];
  assign head_index = index_sr[LATENCY-1];

endmodule

// File: rtl/alu4_word_sequencer.sv
// Slices a word operation into LSB-first nibble issues to the pipelined 4-bit ALU and
// reassembles the returned Z nibbles (plus final carry for arithmetic) into a word result.
module alu4_word_sequencer
  import alu4_pkg::*;
#(
  parameter  int NIBBLES = 4,
  parameter  int LATENCY = DEFAULT_LATENCY,
  localparam int W       = ALU_NIBBLE_W * NIBBLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [W-1:0]            cmd_x,
  input  logic [W-1:0]            cmd_y,
  input  logic [2:0]              cmd_op,
  input  logic                    cmd_cmpl_x,
  input  logic                    cmd_cmpl_y,
  input  logic                    cmd_carry_in,
  input  logic                    cmd_end_bar,
  output logic [ALU_NIBBLE_W-1:0] alu_x,
  output logic [ALU_NIBBLE_W-1:0] alu_y,
  output logic                    alu_carry_in,
  output logic                    alu_end_bar,
  output logic                    alu_cmpl_x,
  output logic                    alu_cmpl_y,
  output logic                    alu_op_xor,
  output logic                    alu_op_and,
  output logic                    alu_op_arith,
  input  logic [ALU_NIBBLE_W-1:0] alu_z,
  input  logic                    alu_carry_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [W-1:0]            res_data,
  output logic                    res_carry,
  output seq_state_t              fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // cmd_ready is high only in IDLE, res_valid only in DONE, and res_* hold until taken.

  localparam logic [2:0] LAST = 3'(NIBBLES - 1);

  seq_state_t state, state_nx;
  logic       issue;

  logic [W-1:0] x_q, y_q;
  logic [2:0]   op_q;
  logic         cmpl_x_q, cmpl_y_q, cin_q, end_bar_q, arith_q;
  logic [2:0]   k;
  logic [3:0]   cnt;
  logic         issue_q;
  logic [2:0]   issue_idx_q;
  logic         head_valid;
  logic [2:0]   head_index;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE: if (cmd_valid) state_nx = ISSUE;
      ISSUE: begin
        issue = 1'b1;
        if (k == LAST)   state_nx = DRAIN;
        else if (arith_q) state_nx = WAIT_CARRY;
      end
      WAIT_CARRY: begin
        // cnt reaches zero in the cycle the previous nibble's carry is on alu_carry_out
        if (cnt == 4'd0) begin
          issue = 1'b1;
          if (k == LAST) state_nx = DRAIN;
        end
      end
      DRAIN: if (head_valid && head_index == LAST) state_nx = DONE;
      DONE:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      op_q         <= '0;
      cmpl_x_q     <= 1'b0;
      cmpl_y_q     <= 1'b0;
      cin_q        <= 1'b0;
      end_bar_q    <= 1'b0;
      arith_q      <= 1'b0;
      k            <= '0;
      cnt          <= '0;
      issue_q      <= 1'b0;
      issue_idx_q  <= '0;
      alu_x        <= '0;
      alu_y        <= '0;
      alu_carry_in <= 1'b0;
      alu_end_bar  <= 1'b0;
      alu_cmpl_x   <= 1'b0;
      alu_cmpl_y   <= 1'b0;
      alu_op_xor   <= 1'b0;
      alu_op_and   <= 1'b0;
      alu_op_arith <= 1'b0;
      res_data     <= '0;
      res_carry    <= 1'b0;
    end else begin
      state <= state_nx;

      if (state == IDLE && cmd_valid) begin
        x_q       <= cmd_x;
        y_q       <= cmd_y;
        op_q      <= op_legal(cmd_op) ? cmd_op : 3'b000;
        arith_q   <= (cmd_op == OP_ARITH);
        cmpl_x_q  <= cmd_cmpl_x;
        cmpl_y_q  <= cmd_cmpl_y;
        cin_q     <= cmd_carry_in;
        end_bar_q <= cmd_end_bar;
        k         <= '0;
        res_data  <= '0;
        res_carry <= 1'b0;
      end

      // ALU drive lines return to zero in every cycle without an issue
      alu_x        <= '0;
      alu_y        <= '0;
      alu_carry_in <= 1'b0;
      alu_end_bar  <= 1'b0;
      alu_cmpl_x   <= 1'b0;
      alu_cmpl_y   <= 1'b0;
      alu_op_xor   <= 1'b0;
      alu_op_and   <= 1'b0;
      alu_op_arith <= 1'b0;

      if (issue) begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (k == 3'(i)) begin
            alu_x <= x_q[i*ALU_NIBBLE_W +: ALU_NIBBLE_W];
            alu_y <= y_q[i*ALU_NIBBLE_W +: ALU_NIBBLE_W];
          end
        end
        alu_carry_in <= arith_q & ((k == 3'd0) ? cin_q : alu_carry_out);
        alu_end_bar  <= end_bar_q;
        alu_cmpl_x   <= cmpl_x_q;
        alu_cmpl_y   <= cmpl_y_q;
        alu_op_xor   <= op_q[0];
        alu_op_and   <= op_q[1];
        alu_op_arith <= op_q[2];
        k            <= k + 3'd1;
        cnt          <= 4'(LATENCY);
      end else if (state == WAIT_CARRY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      issue_q     <= issue;
      issue_idx_q <= k;

      if (head_valid) begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (head_index == 3'(i)) res_data[i*ALU_NIBBLE_W +: ALU_NIBBLE_W] <= alu_z;
        end
        if (arith_q) res_carry <= alu_carry_out;
      end
    end
  end

  alu4_inflight_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (issue_q),
    .in_index   (issue_idx_q),
    .head_valid (head_valid),
    .head_index (head_index)
  );

  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_alu4_word_sequencer.sv
// Bench for alu4_word_sequencer with a behavioural LATENCY-delay 4-bit ALU and a result scoreboard.
module tb_alu4_word_sequencer;
  import alu4_pkg::*;

  localparam int N   = 4;
  localparam int L   = 8;
  localparam int W   = 4 * N;
  localparam int LAT_LOGIC = N + L + 1;
  localparam int LAT_ARITH = N * (L + 1) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [W-1:0] cmd_x, cmd_y;
  logic [2:0]   cmd_op;
  logic         cmd_cmpl_x, cmd_cmpl_y, cmd_carry_in, cmd_end_bar;
  logic [3:0]   alu_x, alu_y, alu_z;
  logic         alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y;
  logic         alu_op_xor, alu_op_and, alu_op_arith, alu_carry_out;
  logic         res_valid, res_ready, res_carry;
  logic [W-1:0] res_data;
  seq_state_t   fsm_state;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_c_q[$];

  int   cyc = 0;
  int   issue_cyc_q[$];
  logic cin_log[$];
  logic eb_log[$];

  always #5 clk = ~clk;

  alu4_word_sequencer #(.NIBBLES(N), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_op(cmd_op),
    .cmd_cmpl_x(cmd_cmpl_x), .cmd_cmpl_y(cmd_cmpl_y),
    .cmd_carry_in(cmd_carry_in), .cmd_end_bar(cmd_end_bar),
    .alu_x(alu_x), .alu_y(alu_y), .alu_carry_in(alu_carry_in),
    .alu_end_bar(alu_end_bar), .alu_cmpl_x(alu_cmpl_x), .alu_cmpl_y(alu_cmpl_y),
    .alu_op_xor(alu_op_xor), .alu_op_and(alu_op_and), .alu_op_arith(alu_op_arith),
    .alu_z(alu_z), .alu_carry_out(alu_carry_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry),
    .fsm_state(fsm_state)
  );

  // One nibble of the ALU: returns {carry, z}
  function automatic logic [4:0] alu_nib(input logic [3:0] x, input logic [3:0] y,
                                         input logic [2:0] op, input logic cx, input logic cy,
                                         input logic cin);
    logic [3:0] xa, ya;
    xa = x ^ {4{cx}};
    ya = y ^ {4{cy}};
    case (op)
      OP_ARITH: return {1'b0, xa} + {1'b0, ya} + {4'd0, cin};
      OP_AND:   return {1'b0, xa & ya};
      OP_XOR:   return {1'b0, xa ^ ya};
      default:  return 5'd0;
    endcase
  endfunction

  // Behavioural ALU: inputs sampled at the edge, result visible LATENCY cycles after presentation
  logic [4:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= alu_nib(alu_x, alu_y, {alu_op_arith, alu_op_and, alu_op_xor},
                        alu_cmpl_x, alu_cmpl_y, alu_carry_in);
    for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
  end
  assign alu_z         = mpipe[L-1][3:0];
  assign alu_carry_out = mpipe[L-1][4];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_op_xor | alu_op_and | alu_op_arith) begin
      issue_cyc_q.push_back(cyc);
      cin_log.push_back(alu_carry_in);
      eb_log.push_back(alu_end_bar);
    end
  end

  task automatic clear_logs();
    issue_cyc_q.delete();
    cin_log.delete();
    eb_log.delete();
  endtask

  // Word-level reference: chain nibble results LSB-first
  task automatic push_expected(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                               input logic cx, input logic cy, input logic cin);
    logic [W-1:0] r;
    logic         c;
    logic [4:0]   s;
    r = '0;
    c = (op == OP_ARITH) ? cin : 1'b0;
    for (int i = 0; i < N; i++) begin
      s = alu_nib(x[i*4 +: 4], y[i*4 +: 4], op, cx, cy, c);
      r[i*4 +: 4] = s[3:0];
      c = (op == OP_ARITH) ? s[4] : 1'b0;
    end
    exp_q.push_back(r);
    exp_c_q.push_back(c);
  endtask

  task automatic drive_cmd(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                           input logic cx, input logic cy, input logic cin, input logic eb,
                           input bit push);
    int n;
    cmd_x = x; cmd_y = y; cmd_op = op;
    cmd_cmpl_x = cx; cmd_cmpl_y = cy; cmd_carry_in = cin; cmd_end_bar = eb;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    else passed++;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (push) push_expected(x, y, op, cx, cy, cin);
  endtask

  // Called at the negedge right after the accept edge
  task automatic collect(input string tag, input int exp_lat, input int hold);
    int           lat;
    logic [W-1:0] ed;
    logic         ec;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    ed = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    ec = exp_c_q.size() > 0 ? exp_c_q.pop_front() : 1'b0;
    total++;
    if (res_valid !== 1'b1) begin
      $display("FAIL %s_timeout: res_valid=%b after %0d cycles, required 1", tag, res_valid, lat);
      return;
    end
    passed++;
    total++;
    if (lat !== exp_lat) $display("FAIL %s_latency: got %0d cycles, required %0d", tag, lat, exp_lat);
    else passed++;
    total++;
    if (res_data !== ed) $display("FAIL %s_data: got %h, required %h", tag, res_data, ed);
    else passed++;
    total++;
    if (res_carry !== ec) $display("FAIL %s_carry: got %b, required %b", tag, res_carry, ec);
    else passed++;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_x = W'($urandom_range(0, 65535));
      cmd_op = OP_XOR;
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || res_data !== ed || res_carry !== ec || cmd_ready !== 1'b0)
        $display("FAIL %s_hold: valid=%b data=%h carry=%b ready=%b, required 1 %h %b 0",
                 tag, res_valid, res_data, res_carry, cmd_ready, ed, ec);
      else passed++;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL %s_release: res_valid=%b cmd_ready=%b, required 0 1", tag, res_valid, cmd_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== '0 || res_carry !== 1'b0 ||
        {alu_x, alu_y, alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y,
         alu_op_xor, alu_op_and, alu_op_arith} !== 13'd0)
      $display("FAIL reset_outputs: ready=%b valid=%b data=%h carry=%b alu_x=%h alu_y=%h, required 1 0 0 0 0 0",
               cmd_ready, res_valid, res_data, res_carry, alu_x, alu_y);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (fsm_state !== IDLE || cmd_ready !== 1'b1)
      $display("FAIL reset_idle: state=%0d ready=%b, required IDLE 1", fsm_state, cmd_ready);
    else passed++;
  endtask

  task automatic test_arith_carry_chain();
    clear_logs();
    drive_cmd(16'h0FFF, 16'h0001, OP_ARITH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    collect("arith_0fff", LAT_ARITH, 0);
    total++;
    if (issue_cyc_q.size() != N || issue_cyc_q[1] - issue_cyc_q[0] != L + 1 ||
        issue_cyc_q[3] - issue_cyc_q[2] != L + 1)
      $display("FAIL arith_spacing: %0d issues, required %0d spaced %0d apart", issue_cyc_q.size(), N, L + 1);
    else passed++;

    clear_logs();
    drive_cmd(16'hFFFF, 16'h0001, OP_ARITH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    collect("arith_ffff", LAT_ARITH, 0);
    total++;
    if (cin_log.size() != N || {cin_log[0], cin_log[1], cin_log[2], cin_log[3]} !== 4'b0111)
      $display("FAIL arith_carry_in: %0d issues, carry_in seq %b%b%b%b, required 0111",
               cin_log.size(), cin_log[0], cin_log[1], cin_log[2], cin_log[3]);
    else passed++;
  endtask

  task automatic test_logic_back_to_back();
    clear_logs();
    drive_cmd(16'hA5A5, 16'h0FF0, OP_XOR, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    collect("xor", LAT_LOGIC, 0);
    total++;
    if (issue_cyc_q.size() != N || issue_cyc_q[3] - issue_cyc_q[0] != N - 1 ||
        eb_log[0] !== 1'b1 || eb_log[3] !== 1'b1)
      $display("FAIL xor_issue: %0d issues span %0d cycles, required %0d in %0d with end_bar=1",
               issue_cyc_q.size(), issue_cyc_q[3] - issue_cyc_q[0], N, N - 1);
    else passed++;
  endtask

  task automatic test_subtract();
    drive_cmd(16'h0005, 16'h0003, OP_ARITH, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    collect("subtract", LAT_ARITH, 0);
  endtask

  task automatic test_hold();
    drive_cmd(16'h1234, 16'h00FF, OP_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    collect("hold", LAT_LOGIC, 10);
  endtask

  task automatic test_bad_op();
    drive_cmd(16'hFFFF, 16'hFFFF, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    collect("bad_op", LAT_LOGIC, 0);
  endtask

  task automatic test_reset_mid_op();
    int n;
    clear_logs();
    drive_cmd(16'hFFFF, 16'h0001, OP_ARITH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (issue_cyc_q.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 ||
        {alu_x, alu_y, alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y,
         alu_op_xor, alu_op_and, alu_op_arith} !== 13'd0)
      $display("FAIL midreset_outputs: ready=%b valid=%b alu_x=%h arith=%b, required 1 0 0 0",
               cmd_ready, res_valid, alu_x, alu_op_arith);
    else passed++;
    drive_cmd(16'h1111, 16'h2222, OP_ARITH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    collect("after_reset", LAT_ARITH, 0);
  endtask

  task automatic test_random();
    logic [2:0] ops [3];
    logic [2:0] op;
    ops[0] = OP_XOR; ops[1] = OP_AND; ops[2] = OP_ARITH;
    for (int i = 0; i < 6; i++) begin
      op = ops[$urandom_range(0, 2)];
      drive_cmd(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), op,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b1);
      collect("random", (op == OP_ARITH) ? LAT_ARITH : LAT_LOGIC, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_op = '0;
    cmd_cmpl_x = 1'b0; cmd_cmpl_y = 1'b0; cmd_carry_in = 1'b0; cmd_end_bar = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_arith_carry_chain();
    test_logic_back_to_back();
    test_subtract();
    test_hold();
    test_bad_op();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
